// File: rtl/nibble_serial_pkg.sv
// Shared definitions for the nibble-serial adder controller: slice width,
// FSM state type and the iteration-counter width helper.
package nibble_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-nibble operation still needs a one-bit counter.
    function automatic int cnt_width(input int nibbles);
        if (nibbles <= 1) return 1;
        return $clog2(nibbles);
    endfunction

endpackage

// File: rtl/full_adder_4_bits.sv
// Shared combinational 4-bit adder slice reused by the nibble-serial controller.
module full_adder_4_bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide add built from one shared 4-bit adder, one nibble per clock, LSB first.
// Optional subtract mode is enabled by defining NIBBLE_SERIAL_SUB_EN.
module nibble_serial_add_ctrl
    import nibble_serial_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] op_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] op_b,
    input  logic                      cin,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic                      op_sub,
`endif
    output logic                      out_valid,
    output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
    output logic                      out_carry,
    output logic                      busy
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int CNT_W = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    state_t               state;
    state_t               state_nxt;
    logic [W-1:0]         a_sh;
    logic [W-1:0]         b_sh;
    logic [W-1:0]         res;
    logic [W-1:0]         res_nxt;
    logic                 c_reg;
    logic [CNT_W-1:0]     cnt;
    logic [NIBBLE_W-1:0]  add_sum;
    logic                 add_carry;
    logic                 accept;
    logic                 last;
    logic                 sub_sel;

`ifdef NIBBLE_SERIAL_SUB_EN
    assign sub_sel = op_sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE);
    assign last      = (state == RUN) && (cnt == CNT_LAST);

    full_adder_4_bits u_adder (
        .a     (a_sh[NIBBLE_W-1:0]),
        .b     (b_sh[NIBBLE_W-1:0]),
        .cin   (c_reg),
        .sum   (add_sum),
        .carry (add_carry)
    );

    // New nibble enters at the top; after NIBBLES shifts the LSB nibble sits at bit 0.
    assign res_nxt = (res >> NIBBLE_W) | (W'(add_sum) << (W - NIBBLE_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res       <= '0;
            c_reg     <= 1'b0;
            cnt       <= '0;
            out_sum   <= '0;
            out_carry <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1, so the carry-in is forced high.
            a_sh  <= op_a;
            b_sh  <= sub_sel ? ~op_b : op_b;
            c_reg <= sub_sel ? 1'b1 : cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> NIBBLE_W;
            b_sh  <= b_sh >> NIBBLE_W;
            c_reg <= add_carry;
            res   <= res_nxt;
            cnt   <= cnt + CNT_W'(1);
            if (last) begin
                out_sum   <= res_nxt;
                out_carry <= add_carry;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl: random and directed operations
// against an arithmetic reference model; NIBBLE_SERIAL_SUB_EN adds subtract cases.
module tb_nibble_serial_add_ctrl;

    localparam int  NIBBLES = 4;
    localparam int  W       = 4 * NIBBLES;
    localparam time PERIOD  = 10;
`ifdef NIBBLE_SERIAL_SUB_EN
    localparam bit  SUB_EN  = 1'b1;
`else
    localparam bit  SUB_EN  = 1'b0;
`endif

    typedef struct {
        logic [W:0] val;
        time        due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         op_sub_r;
    logic         out_valid;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         busy;

    exp_t         q[$];
    logic [W:0]   held;
    int           checks   = 0;
    int           failures = 0;

    always #(PERIOD / 2) clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
`ifdef NIBBLE_SERIAL_SUB_EN
        .op_sub    (op_sub_r),
`endif
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .busy      (busy)
    );

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        longint unsigned av, bv, r;
        av = longint'(a);
        bv = longint'(b);
        if (s) begin
            r = (av - bv) & ((64'd1 << W) - 1);
            return {(av >= bv) ? 1'b1 : 1'b0, r[W-1:0]};
        end
        r = av + bv + longint'(c);
        return r[W:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Presents an operation and waits until it is accepted; waited counts the
    // falling edges spent with in_ready low. in_valid is left high.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, output int waited);
        bit done;
        done     = 1'b0;
        waited   = 0;
        op_a     = a;
        op_b     = b;
        cin      = c;
        op_sub_r = s;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{val: model(a, b, c, s), due: $time + (NIBBLES + 1) * PERIOD});
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                waited++;
            end
        end
        if (!done) check("accept_timeout", 64'd0, 64'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("busy_vs_ready", 64'(busy), 64'(!in_ready));
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("result", 64'({out_carry, out_sum}), 64'(e.val));
                    check("latency", 64'($time), 64'(e.due));
                    held = e.val;
                end
            end else begin
                check("hold", 64'({out_carry, out_sum}), 64'(held));
            end
        end
    end

    initial begin
        #(200000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [W-1:0] ra, rb;
        logic rc, rs;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        cin      = 1'b0;
        op_sub_r = 1'b0;
        held     = '0;
        #1;
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_sum",   64'(out_sum),   64'd0);
        check("reset_out_carry", 64'(out_carry), 64'd0);
        check("reset_busy",      64'(busy),      64'd0);
        #21 rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, w);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        issue(16'h1234, 16'h4321, 1'b1, 1'b0, w);
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        issue(16'h1111, 16'h2222, 1'b0, 1'b0, w);
        issue(16'hAAAA, 16'h5555, 1'b0, 1'b0, w);
        check("busy_ignore_cycles", 64'(w), 64'(NIBBLES + 1));
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        for (int i = 0; i < 100; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = SUB_EN ? 1'($urandom) : 1'b0;
            issue(ra, rb, rc, rs, w);
            check("issue_interval", 64'(w), (i == 0) ? 64'd0 : 64'(NIBBLES + 1));
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        issue(16'h3333, 16'h4444, 1'b0, 1'b0, w);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        held  = '0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_sum",   64'(out_sum),   64'd0);
        check("midrst_out_carry", 64'(out_carry), 64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        check("midrst_busy",      64'(busy),      64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0, w);
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        if (SUB_EN) begin
            issue(16'h0005, 16'h0007, 1'b0, 1'b1, w);
            issue(16'h0007, 16'h0005, 1'b1, 1'b1, w);
            in_valid = 1'b0;
        end

        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that reuses one 4-bit adder datapath to add two wide operands nibble by nibble, LSB first.
- Carry is held in a register between nibbles.
- Sits between a requester issuing wide add operations and a single shared 4-bit adder, trading latency for area.
- Valid/ready request side; registered, one-cycle-pulse result side.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; legal range 1..16. Operand width W = 4*NIBBLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request (high only in IDLE).
- op_a  in  W  operand A, sampled on accept.
- op_b  in  W  operand B, sampled on accept.
- cin  in  1  carry-in to the LSB nibble, sampled on accept.
- out_valid  out  1  one-cycle pulse: out_sum/out_carry are new.
- out_sum  out  W  result, registered, held until the next result.
- out_carry  out  1  carry out of the MSB nibble, registered, held.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_sum=0, out_carry=0, busy=0, internal operand/result/carry/counter registers 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Accept when in_valid && in_ready.
  - On the accept edge E0: a_sh<=op_a, b_sh<=op_b, c_reg<=cin, cnt<=0, state<=RUN.
- RUN:
  - Adder inputs are a=a_sh[3:0], b=b_sh[3:0], cin=c_reg.
  - Each edge: c_reg<=adder carry; res<={adder sum, res[W-1:4]}; a_sh and b_sh shift right by 4; cnt<=cnt+1.
  - On the edge where cnt==NIBBLES-1: out_sum<=final res value (including this nibble), out_carry<=adder carry, state<=DONE.
- DONE: out_valid=1 for exactly this cycle; next edge state<=IDLE.
- Latency: out_valid is high during the cycle after edge E0+NIBBLES. Minimum issue interval is NIBBLES+2 cycles (6 for the default).
- Result side has no backpressure: out_valid is a pulse; the consumer must capture it.
- in_valid while not IDLE: ignored. op_a, op_b and cin are not sampled; no error flag.
- NIBBLES=1: RUN lasts one edge; the result equals a single adder pass.
- cnt width: max(1, clog2(NIBBLES)). No wrap within an operation.
- Arithmetic: {out_carry,out_sum} = op_a + op_b + cin, exactly W+1 bits, modulo nothing.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. A partial result is never presented.
- in_ready and busy are decoded from state registers only, with no combinational path from in_valid.

Optional Feature:
- Macro NIBBLE_SERIAL_SUB_EN.
- When defined:
  - Extra input port op_sub (1 bit), sampled on accept.
  - If op_sub=1: b_sh<=~op_b and c_reg<=1 (cin ignored). Result = op_a - op_b mod 2^W.
  - out_carry=1 means no borrow (op_a >= op_b).
- When undefined: no op_sub port; addition only. Behaviour is identical to the above with op_sub tied 0.

Decomposition:
- Shared package nibble_serial_pkg:
  - NIBBLE_W=4.
  - State enum type (IDLE, RUN, DONE).
  - Function computing cnt width from NIBBLES.
- Natural sub-module: the team's existing full_adder_4_bits (a, b, cin, sum, carry), instantiated once as the shared combinational datapath.
- The controller holds all sequential logic.

Test Plan:
- Carry ripple: NIBBLES=4, op_a=16'hFFFF, op_b=16'h0001, cin=0 -> out_sum=16'h0000, out_carry=1; out_valid pulses once, in the cycle after edge E0+4.
- Basic add: op_a=16'h1234, op_b=16'h4321, cin=1 -> out_sum=16'h5556, out_carry=0; outputs hold after the pulse until the next result.
- Ignore while busy: after accept, drive in_valid=1 with op_a=16'hAAAA, op_b=16'h5555 during RUN -> in_ready=0 for 5 cycles, first result unaffected, second op accepted only in the following IDLE.
- Back-to-back: in_valid held 1 with a stream of 100 random operands -> one accept every 6 cycles; every result matches a+b+cin.
- Reset mid-op: assert rst_n=0 two cycles into RUN -> out_valid=0, out_sum=0, out_carry=0, in_ready=1 asynchronously. Next op 16'h00FF+16'h0001 -> 16'h0100, carry 0.
- NIBBLE_SERIAL_SUB_EN: 16'h0005-16'h0007 -> 16'hFFFE, carry 0; 16'h0007-16'h0005 -> 16'h0002, carry 1.
